// File: rtl/ball_motion_ctrl.sv
// ---------------------------------------------------------------------------
// ball_motion_ctrl
//   Owns the Pong ball position and direction. A free-running frame counter
//   (enabled by run) raises a pending tick once per frame; each taken tick
//   erases the ball at its old position, steps it one pixel per axis with
//   bounce at the screen edges, and redraws it at the new position, using
//   a one-cycle draw_start handshake towards a 4x4 square plotter.
//
// Ports
//   clk          system clock, all state on the rising edge
//   resetn       asynchronous active-low reset
//   run          1 = frame counter advances and the ball moves
//   draw_busy    plotter busy (high the cycle after draw_start until done)
//   draw_start   one-cycle request, plotter latches draw_x/y/colour
//   draw_x       square top-left x
//   draw_y       square top-left y
//   draw_colour  square colour
//   ball_x       current ball x
//   ball_y       current ball y
// ---------------------------------------------------------------------------
module ball_motion_ctrl #(
    parameter int unsigned SCREEN_W    = 160,
    parameter int unsigned SCREEN_H    = 120,
    parameter int unsigned BALL_SIZE   = 4,
    parameter int unsigned FRAME_DIV   = 833333,
    parameter int unsigned START_X     = 78,
    parameter int unsigned START_Y     = 58,
    parameter logic [2:0]  BG_COLOUR   = 3'b000,
    parameter logic [2:0]  BALL_COLOUR = 3'b111
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       run,
    input  logic       draw_busy,
    output logic       draw_start,
    output logic [7:0] draw_x,
    output logic [6:0] draw_y,
    output logic [2:0] draw_colour,
    output logic [7:0] ball_x,
    output logic [6:0] ball_y
);

    localparam int unsigned CW       = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_DIV - 1);
    localparam logic [7:0] XMAX      = 8'(SCREEN_W - BALL_SIZE);
    localparam logic [6:0] YMAX      = 7'(SCREEN_H - BALL_SIZE);
    localparam logic [7:0] X0        = 8'(START_X);
    localparam logic [6:0] Y0        = 7'(START_Y);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ERASE      = 3'd1,
        ST_ERASE_WAIT = 3'd2,
        ST_MOVE       = 3'd3,
        ST_DRAW       = 3'd4,
        ST_DRAW_WAIT  = 3'd5
    } state_t;

    state_t        state_r;
    state_t        next_state_s;
    logic [CW-1:0] cnt_r;
    logic          tick_pending_r;
    logic          tick_s;
    logic          take_tick_s;
    logic          wait_done_s;
    logic          wait_skip_r;
    logic          dir_x_r;        // 1 = moving +
    logic          dir_y_r;
    logic [7:0]    ball_x_r;
    logic [6:0]    ball_y_r;
    logic [8:0]    step_x_s;       // {new dir, new pos}
    logic [7:0]    step_y_s;
    logic          draw_start_r;
    logic [7:0]    draw_x_r;
    logic [6:0]    draw_y_r;
    logic [2:0]    draw_colour_r;

    // One-pixel step with edge bounce: returns {dir, pos}.
    function automatic logic [8:0] step_x(input logic [7:0] pos, input logic dir);
        logic [8:0] r;
        if (dir) begin
            if (pos == XMAX) r = {1'b0, XMAX - 8'd1};
            else             r = {1'b1, pos + 8'd1};
        end else begin
            if (pos == 8'd0) r = {1'b1, 8'd1};
            else             r = {1'b0, pos - 8'd1};
        end
        return r;
    endfunction

    function automatic logic [7:0] step_y(input logic [6:0] pos, input logic dir);
        logic [7:0] r;
        if (dir) begin
            if (pos == YMAX) r = {1'b0, YMAX - 7'd1};
            else             r = {1'b1, pos + 7'd1};
        end else begin
            if (pos == 7'd0) r = {1'b1, 7'd1};
            else             r = {1'b0, pos - 7'd1};
        end
        return r;
    endfunction

    assign step_x_s    = step_x(ball_x_r, dir_x_r);
    assign step_y_s    = step_y(ball_y_r, dir_y_r);
    assign tick_s      = run && (cnt_r == CNT_LAST);
    // A pending tick is only taken while running, so run=0 parks in IDLE.
    assign take_tick_s = (state_r == ST_IDLE) && tick_pending_r && run;
    // The cycle right after draw_start is ignored; busy may not be up yet.
    assign wait_done_s = !wait_skip_r && !draw_busy;

    // Frame counter: counts 0..FRAME_DIV-1 while run, holds otherwise.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_r <= {CW{1'b0}};
        end else if (run) begin
            if (cnt_r == CNT_LAST) cnt_r <= {CW{1'b0}};
            else                   cnt_r <= cnt_r + CW'(1'b1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Pending tick flag; a tick arriving while already pending is dropped.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)          tick_pending_r <= 1'b0;
        else if (take_tick_s) tick_pending_r <= 1'b0;
        else if (tick_s)      tick_pending_r <= 1'b1;
        else                  tick_pending_r <= tick_pending_r;
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_r <= ST_DRAW;
        else         state_r <= next_state_s;
    end

    // Next-state logic. DRAW is held until its request has been issued,
    // which covers the first pass after reset where draw_start starts at 0.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (take_tick_s) next_state_s = ST_ERASE;
                else             next_state_s = ST_IDLE;
            end
            ST_ERASE:      next_state_s = ST_ERASE_WAIT;
            ST_ERASE_WAIT: begin
                if (wait_done_s) next_state_s = ST_MOVE;
                else             next_state_s = ST_ERASE_WAIT;
            end
            ST_MOVE:       next_state_s = ST_DRAW;
            ST_DRAW: begin
                if (draw_start_r) next_state_s = ST_DRAW_WAIT;
                else              next_state_s = ST_DRAW;
            end
            ST_DRAW_WAIT: begin
                if (wait_done_s) next_state_s = ST_IDLE;
                else             next_state_s = ST_DRAW_WAIT;
            end
            default:       next_state_s = ST_IDLE;
        endcase
    end

    // Ball position and direction, stepped once in MOVE.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ball_x_r <= X0;
            ball_y_r <= Y0;
            dir_x_r  <= 1'b1;
            dir_y_r  <= 1'b1;
        end else if (state_r == ST_MOVE) begin
            ball_x_r <= step_x_s[7:0];
            dir_x_r  <= step_x_s[8];
            ball_y_r <= step_y_s[6:0];
            dir_y_r  <= step_y_s[7];
        end else begin
            ball_x_r <= ball_x_r;
            ball_y_r <= ball_y_r;
            dir_x_r  <= dir_x_r;
            dir_y_r  <= dir_y_r;
        end
    end

    // Plotter request registers: draw_start aligned with ERASE/DRAW, and the
    // square fields loaded only on entry to ERASE/DRAW so they stay stable
    // through the following wait state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            draw_start_r  <= 1'b0;
            draw_x_r      <= X0;
            draw_y_r      <= Y0;
            draw_colour_r <= BALL_COLOUR;
            wait_skip_r   <= 1'b0;
        end else begin
            draw_start_r <= (next_state_s == ST_ERASE) || (next_state_s == ST_DRAW);
            wait_skip_r  <= draw_start_r;
            if (next_state_s == ST_ERASE) begin
                draw_x_r      <= ball_x_r;
                draw_y_r      <= ball_y_r;
                draw_colour_r <= BG_COLOUR;
            end else if (next_state_s == ST_DRAW) begin
                if (state_r == ST_MOVE) begin
                    draw_x_r <= step_x_s[7:0];
                    draw_y_r <= step_y_s[6:0];
                end else begin
                    draw_x_r <= ball_x_r;
                    draw_y_r <= ball_y_r;
                end
                draw_colour_r <= BALL_COLOUR;
            end else begin
                draw_x_r      <= draw_x_r;
                draw_y_r      <= draw_y_r;
                draw_colour_r <= draw_colour_r;
            end
        end
    end

    assign draw_start  = draw_start_r;
    assign draw_x      = draw_x_r;
    assign draw_y      = draw_y_r;
    assign draw_colour = draw_colour_r;
    assign ball_x      = ball_x_r;
    assign ball_y      = ball_y_r;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ball_motion_ctrl
//   Three instances share clk/resetn, each with its own run and stub plotter:
//     u0 default geometry (FRAME_DIV=20) for the normal frame sequence,
//        stretched busy, and mid-sequence reset;
//     u1 starting at x=XMAX (156) for the right-wall bounce;
//     u2 on a 12x12 screen starting at (6,6) so the ball travels diagonally
//        to (8,8), then back to the (0,0) corner.
//   Expected draw requests live in a table of records.
// ---------------------------------------------------------------------------
module tb_ball_motion_ctrl;

    logic       clk;
    logic       resetn;
    logic [2:0] run_v;
    logic       ds  [3];
    logic       bsy [3];
    logic [7:0] dx  [3];
    logic [6:0] dy  [3];
    logic [2:0] dc  [3];
    logic [7:0] bx  [3];
    logic [6:0] by  [3];
    int         bc  [3];
    int         busy_len;
    int         start_cnt [3];
    int         n_checks;
    int         n_fail;

    typedef struct {
        int inst;
        int x;
        int y;
        int c;
    } rec_t;

    rec_t tbl[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ball_motion_ctrl #(.FRAME_DIV(20)) u0 (
        .clk(clk), .resetn(resetn), .run(run_v[0]), .draw_busy(bsy[0]),
        .draw_start(ds[0]), .draw_x(dx[0]), .draw_y(dy[0]), .draw_colour(dc[0]),
        .ball_x(bx[0]), .ball_y(by[0]));

    ball_motion_ctrl #(.FRAME_DIV(20), .START_X(156), .START_Y(50)) u1 (
        .clk(clk), .resetn(resetn), .run(run_v[1]), .draw_busy(bsy[1]),
        .draw_start(ds[1]), .draw_x(dx[1]), .draw_y(dy[1]), .draw_colour(dc[1]),
        .ball_x(bx[1]), .ball_y(by[1]));

    ball_motion_ctrl #(.FRAME_DIV(20), .SCREEN_W(12), .SCREEN_H(12),
                       .START_X(6), .START_Y(6)) u2 (
        .clk(clk), .resetn(resetn), .run(run_v[2]), .draw_busy(bsy[2]),
        .draw_start(ds[2]), .draw_x(dx[2]), .draw_y(dy[2]), .draw_colour(dc[2]),
        .ball_x(bx[2]), .ball_y(by[2]));

    // Stub plotters: busy for busy_len cycles starting the cycle after draw_start.
    always @(posedge clk or negedge resetn) begin
        for (int i = 0; i < 3; i++) begin
            if (!resetn) begin
                bc[i]        <= 0;
                start_cnt[i] <= 0;
            end else begin
                if (ds[i])          bc[i] <= busy_len;
                else if (bc[i] > 0) bc[i] <= bc[i] - 1;
                if (ds[i]) start_cnt[i] <= start_cnt[i] + 1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) bsy[i] = (bc[i] != 0);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Wait (bounded) for a draw_start on instance idx, check the request and
    // ball position, and optionally check the fields stay put while busy.
    task automatic wait_start(input int idx, input int x, input int y, input int c,
                              input bit hold, output int lat);
        int n;
        int m;
        bit ok;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ds[idx] !== 1'b1 && n < 200);
        lat = n;
        if (ds[idx] !== 1'b1) begin
            chk("start_timeout", 0, 1);
            return;
        end
        chk("draw_x", int'(dx[idx]), x);
        chk("draw_y", int'(dy[idx]), y);
        chk("draw_colour", int'(dc[idx]), c);
        chk("ball_x", int'(bx[idx]), x);
        chk("ball_y", int'(by[idx]), y);
        if (hold) begin
            @(negedge clk);
            chk("start_pulse_width", int'(ds[idx]), 0);
            ok = 1'b1;
            m  = 0;
            while (bsy[idx] && m < 100) begin
                if (int'(dx[idx]) != x || int'(dy[idx]) != y ||
                    int'(dc[idx]) != c || ds[idx] !== 1'b0) ok = 1'b0;
                @(negedge clk);
                m++;
            end
            chk("hold_stable", int'(ok), 1);
        end
    endtask

    initial begin
        int pos2 [13];
        int lat;
        n_checks = 0;
        n_fail   = 0;
        busy_len = 16;
        run_v    = 3'b000;
        resetn   = 1'b0;

        // Expected request table.
        tbl.push_back('{0, 78, 58, 0});
        tbl.push_back('{0, 79, 59, 7});
        tbl.push_back('{0, 79, 59, 0});
        tbl.push_back('{0, 80, 60, 7});
        tbl.push_back('{0, 80, 60, 0});
        tbl.push_back('{0, 81, 61, 7});
        tbl.push_back('{1, 156, 50, 0});
        tbl.push_back('{1, 155, 51, 7});
        tbl.push_back('{1, 155, 51, 0});
        tbl.push_back('{1, 154, 52, 7});
        pos2 = '{6, 7, 8, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};
        for (int k = 0; k < 12; k++) begin
            tbl.push_back('{2, pos2[k],   pos2[k],   0});
            tbl.push_back('{2, pos2[k+1], pos2[k+1], 7});
        end

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_draw_start", int'(ds[0]), 0);
        chk("rst_draw_x", int'(dx[0]), 78);
        chk("rst_draw_y", int'(dy[0]), 58);
        chk("rst_draw_colour", int'(dc[0]), 7);
        chk("rst_ball_x", int'(bx[0]), 78);
        chk("rst_ball_y", int'(by[0]), 58);
        chk("rst_u1_ball_x", int'(bx[1]), 156);
        resetn = 1'b1;

        // First pass after reset: draw only, then idle while run=0.
        wait_start(0, 78, 58, 7, 1'b1, lat);
        repeat (60) @(negedge clk);
        chk("no_erase_after_reset", start_cnt[0], 1);
        chk("frozen_ball_x", int'(bx[0]), 78);

        // Table-driven frames; only the instance under test runs.
        for (int i = 0; i < tbl.size(); i++) begin
            run_v = 3'b000;
            run_v[tbl[i].inst] = 1'b1;
            wait_start(tbl[i].inst, tbl[i].x, tbl[i].y, tbl[i].c, 1'b1, lat);
        end
        run_v = 3'b000;

        // Stretched busy: ticks pile up but only one is kept pending, so the
        // next erase follows the redraw immediately and the ball still moves
        // one pixel per sequence.
        repeat (5) @(negedge clk);
        busy_len = 30;
        run_v    = 3'b001;
        wait_start(0, 81, 61, 0, 1'b1, lat);
        wait_start(0, 82, 62, 7, 1'b1, lat);
        wait_start(0, 82, 62, 0, 1'b1, lat);
        chk("pending_erase_latency", lat, 2);
        wait_start(0, 83, 63, 7, 1'b1, lat);
        wait_start(0, 83, 63, 0, 1'b0, lat);
        chk("pending_erase_latency2", lat, 2);

        // Reset during ERASE_WAIT takes effect without a clock edge.
        repeat (3) @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        chk("async_rst_draw_start", int'(ds[0]), 0);
        chk("async_rst_draw_x", int'(dx[0]), 78);
        chk("async_rst_draw_y", int'(dy[0]), 58);
        chk("async_rst_draw_colour", int'(dc[0]), 7);
        chk("async_rst_ball_x", int'(bx[0]), 78);
        chk("async_rst_ball_y", int'(by[0]), 58);
        repeat (3) @(negedge clk);
        chk("rst_hold_draw_start", int'(ds[0]), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
